soc_system_clk_en_gen: RTL and testbench

Multi-channel programmable clock-enable generator. It takes the single fabric clock and produces, per channel, a one-cycle enable strobe and a near-50 % divided square wave, with an optional fractional divide. Peripherals such as the ADC interface run from it through enables rather than from a dedicated PLL output. A `locked` flag mirrors PLL semantics: outputs are declared stable only after a settle interval, both following reset and following any reconfiguration.

---
 rtl/soc_system_clk_pkg.sv | 31 +++
 rtl/soc_system_clk_en_gen_if.sv | 24 ++
 rtl/soc_system_clk_div_ch.sv | 84 ++++++++
 rtl/soc_system_clk_en_gen.sv | 112 +++++++++++
 tb/tb_soc_system_clk_en_gen.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_system_clk_pkg.sv
// Shared types and defaults for the clock-enable generator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package soc_system_clk_pkg;

   // Controller state: SETTLE while outputs are not yet declared stable, LOCKED afterwards
   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } clk_fsm_e;

   // Widths of the per-channel configuration word; the top-level CNT_W/FRAC_W track these
   localparam int CFG_DIV_W  = 16;
   localparam int CFG_FRAC_W = 8;

   // Reset-time divisor and settle interval
   localparam int CLK_DEFAULT_DIV = 4;
   localparam int CLK_LOCK_CYCLES = 16;

   // Per-channel configuration: integer divisor and fractional increment
   typedef struct packed {
      logic [CFG_DIV_W-1:0]  div;
      logic [CFG_FRAC_W-1:0] frac;
   } ch_cfg_t;

   // Channel-select width, never narrower than one bit
   function automatic int ch_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/soc_system_clk_en_gen_if.sv
// Configuration write port of the clock-enable generator.
// Latency: n/a (signal bundle only).
// Backpressure: cfg_ready low holds off cfg_valid; requester keeps cfg_* stable until transfer.
interface soc_system_clk_en_gen_if #(
   parameter int CH_W   = 1,
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 8
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [FRAC_W-1:0] cfg_frac;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_frac,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_frac,
      output cfg_ready
   );
endinterface

// File: rtl/soc_system_clk_div_ch.sv
// One divider channel: counter, optional fractional accumulator (CLKEN_FRAC_EN), registered ce/clk.
// Latency: first ce one divisor period after reset or load; outputs registered.
// Backpressure: none; load clears the channel on the same edge it captures the new config.
module soc_system_clk_div_ch
   import soc_system_clk_pkg::*;
#(
   parameter int DEFAULT_DIV = CLK_DEFAULT_DIV
) (
   input  logic    refclk,
   input  logic    rst_n,
   input  logic    load,
   input  ch_cfg_t ld_cfg,
   output logic    ce_o,
   output logic    clk_o
);

   localparam ch_cfg_t RST_CFG = '{div: CFG_DIV_W'(DEFAULT_DIV), frac: '0};

   ch_cfg_t              cfg_q;
   logic [CFG_DIV_W-1:0] cnt_q;
   logic [CFG_DIV_W-1:0] cnt_nxt;
   logic [CFG_DIV_W-1:0] last_cnt;
   logic [CFG_DIV_W:0]   half;
   logic                 run;
   logic                 tc;
   logic                 ext;

   // Terminal count and next counter value; an extended period ends one count later
   always_comb begin
      run      = (cfg_q.div != '0);
      last_cnt = ext ? cfg_q.div : (cfg_q.div - CFG_DIV_W'(1));
      tc       = run && (cnt_q == last_cnt);
      cnt_nxt  = (!run || tc) ? '0 : (cnt_q + CFG_DIV_W'(1));
      half     = ({1'b0, cfg_q.div} + (CFG_DIV_W + 1)'(1)) >> 1;
   end

   // Counter and output registers; clk_o tracks the value the counter is moving to
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q <= RST_CFG;
         cnt_q <= '0;
         ce_o  <= 1'b0;
         clk_o <= 1'b0;
      end else if (load) begin
         cfg_q <= ld_cfg;
         cnt_q <= '0;
         ce_o  <= 1'b0;
         clk_o <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         ce_o  <= tc;
         clk_o <= run && ({1'b0, cnt_nxt} < half);
      end
   end

`ifdef CLKEN_FRAC_EN
   logic [CFG_FRAC_W-1:0] acc_q;
   logic                  ext_q;
   logic [CFG_FRAC_W:0]   acc_sum;

   assign acc_sum = {1'b0, acc_q} + {1'b0, cfg_q.frac};
   assign ext     = ext_q;

   // Accumulate the increment once per period; the carry stretches the following period
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ext_q <= 1'b0;
      end else if (load) begin
         acc_q <= '0;
         ext_q <= 1'b0;
      end else if (tc) begin
         acc_q <= acc_sum[CFG_FRAC_W-1:0];
         ext_q <= acc_sum[CFG_FRAC_W];
      end
   end
`else
   logic unused_frac;

   assign ext         = 1'b0;
   assign unused_frac = ^cfg_q.frac;
`endif

endmodule

// File: rtl/soc_system_clk_en_gen.sv
// Multi-channel clock-enable generator with PLL-style lock flag; fractional divide under CLKEN_FRAC_EN.
// Latency: all outputs registered; a config write relocks LOCK_CYCLES edges after the transfer.
// Backpressure: cfg_ready equals locked, so writes are held off while settling.
module soc_system_clk_en_gen
   import soc_system_clk_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = CFG_DIV_W,
   parameter int FRAC_W      = CFG_FRAC_W,
   parameter int DEFAULT_DIV = CLK_DEFAULT_DIV,
   parameter int LOCK_CYCLES = CLK_LOCK_CYCLES
) (
   input  logic                     refclk,
   input  logic                     rst_n,
   soc_system_clk_en_gen_if.slave   cfg,
   output logic [NUM_CH-1:0]        ce_o,
   output logic [NUM_CH-1:0]        clk_o,
   output logic                     locked
);

   localparam int                 CH_W        = ch_sel_w(NUM_CH);
   localparam int                 SET_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]      NUM_CH_L    = (CH_W + 1)'(NUM_CH);

   clk_fsm_e            state_q;
   clk_fsm_e            state_d;
   logic [SET_W-1:0]    settle_q;
   logic [SET_W-1:0]    settle_d;
   logic [CH_W-1:0]     cfg_ch_w;
   logic [CNT_W-1:0]    cfg_div_w;
   logic                cfg_fire;
   logic                cfg_hit;
   logic [NUM_CH-1:0]   ch_load;
   ch_cfg_t             wr_cfg;

   assign cfg_ch_w  = cfg.cfg_ch;
   assign cfg_div_w = cfg.cfg_div;

   // A transfer to a channel that does not exist is consumed but changes nothing
   assign cfg_fire = cfg.cfg_valid && (state_q == LOCKED);
   assign cfg_hit  = cfg_fire && ({1'b0, cfg_ch_w} < NUM_CH_L);

`ifdef CLKEN_FRAC_EN
   logic [FRAC_W-1:0] cfg_frac_w;

   assign cfg_frac_w  = cfg.cfg_frac;
   assign wr_cfg.frac = CFG_FRAC_W'(cfg_frac_w);
`else
   logic [FRAC_W-1:0] unused_cfg_frac;

   assign unused_cfg_frac = cfg.cfg_frac;
   assign wr_cfg.frac     = '0;
`endif
   assign wr_cfg.div = CFG_DIV_W'(cfg_div_w);

   // Lock state and settle counter registers
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SETTLE;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // Settle for LOCK_CYCLES edges, then lock; any accepted in-range write restarts settling
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = LOCKED;
               settle_d = '0;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         LOCKED: begin
            if (cfg_hit) begin
               state_d  = SETTLE;
               settle_d = '0;
            end
         end
         default: begin
            state_d  = SETTLE;
            settle_d = '0;
         end
      endcase
   end

   assign locked        = (state_q == LOCKED);
   assign cfg.cfg_ready = locked;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_load[i] = cfg_hit && (cfg_ch_w == CH_W'(i));

      soc_system_clk_div_ch #(
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .refclk (refclk),
         .rst_n  (rst_n),
         .load   (ch_load[i]),
         .ld_cfg (wr_cfg),
         .ce_o   (ce_o[i]),
         .clk_o  (clk_o[i])
      );
   end

endmodule

// File: tb/tb_soc_system_clk_en_gen.sv
// Directed bench for soc_system_clk_en_gen: defaults, reconfiguration, lock hold-off, reset.
// Latency: expectations are stated per rising edge counted from reset release or a transfer.
// Backpressure: writes hold cfg_valid until cfg_ready was seen high at an edge.
module tb_soc_system_clk_en_gen;

   // Three channels give a 2-bit select, so code 3 is a real out-of-range channel
   localparam int NCH  = 3;
   localparam int LOCK = 16;

   logic           refclk;
   logic           rst_n;
   logic [NCH-1:0] ce_o;
   logic [NCH-1:0] clk_o;
   logic           locked;

   int tests = 0;
   int fails = 0;
   int edge_n = 0;
   int div_m [NCH];
   int base_m [NCH];
   int lock_base = 0;

   soc_system_clk_en_gen_if #(.CH_W(2), .CNT_W(16), .FRAC_W(8)) cfg_if ();

   soc_system_clk_en_gen #(
      .NUM_CH      (NCH),
      .CNT_W       (16),
      .FRAC_W      (8),
      .DEFAULT_DIV (4),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk (refclk),
      .rst_n  (rst_n),
      .cfg    (cfg_if),
      .ce_o   (ce_o),
      .clk_o  (clk_o),
      .locked (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Expected {ce[2:0], clk[2:0], locked, cfg_ready} after edge edge_n
   function automatic logic [7:0] exp_vec();
      logic [NCH-1:0] ce_e;
      logic [NCH-1:0] clk_e;
      logic           lk;
      int             d;
      int             c;
      for (int i = 0; i < NCH; i++) begin
         ce_e[i]  = 1'b0;
         clk_e[i] = 1'b0;
         d = edge_n - base_m[i];
         if (div_m[i] != 0 && d > 0) begin
            c = d % div_m[i];
            ce_e[i]  = (c == 0);
            clk_e[i] = (c < (div_m[i] + 1) / 2);
         end
      end
      lk = (edge_n - lock_base >= LOCK);
      return {ce_e, clk_e, lk, lk};
   endfunction

   task automatic tick();
      @(posedge refclk);
      #1;
      edge_n++;
   endtask

   task automatic model_reset();
      edge_n    = 0;
      lock_base = 0;
      for (int i = 0; i < NCH; i++) begin
         div_m[i]  = 4;
         base_m[i] = 0;
      end
   endtask

   // Holds a write until it transfers; checks no early transfer and the acceptance edge
   task automatic do_write(input int ch, input int div, input int frac, input string tag);
      int         exp_acc;
      bit         done;
      logic       rdy;
      logic [7:0] obs;
      logic [7:0] ev;
      exp_acc = (edge_n - lock_base >= LOCK) ? edge_n + 1 : lock_base + LOCK + 1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'(ch);
      cfg_if.cfg_div   = 16'(div);
      cfg_if.cfg_frac  = 8'(frac);
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         rdy = cfg_if.cfg_ready;
         tick();
         if (rdy) begin
            done = 1'b1;
            if (ch < NCH) begin
               div_m[ch]  = div;
               base_m[ch] = edge_n;
               lock_base  = edge_n;
            end
            tests++;
            if (edge_n !== exp_acc) begin
               fails++;
               $display("FAIL %s accept_edge: got %0d want %0d", tag, edge_n, exp_acc);
            end
         end
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL %s wait: ce/clk/lock/rdy got %b want %b at edge %0d", tag, obs, ev, edge_n);
         end
      end
      cfg_if.cfg_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s transfer: got none in 64 cycles want one", tag);
      end
   endtask

   task automatic test_reset();
      tests++;
      if (ce_o !== 3'b000) begin fails++; $display("FAIL reset ce_o: got %b want 000", ce_o); end
      tests++;
      if (clk_o !== 3'b000) begin fails++; $display("FAIL reset clk_o: got %b want 000", clk_o); end
      tests++;
      if (locked !== 1'b0) begin fails++; $display("FAIL reset locked: got %b want 0", locked); end
      tests++;
      if (cfg_if.cfg_ready !== 1'b0) begin fails++; $display("FAIL reset cfg_ready: got %b want 0", cfg_if.cfg_ready); end
   endtask

   task automatic test_defaults();
      logic [7:0] obs;
      logic [7:0] ev;
      for (int k = 0; k < 20; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL defaults: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
   endtask

   task automatic test_write_ch1();
      logic [7:0] obs;
      logic [7:0] ev;
      do_write(1, 5, 0, "wr_ch1");
      for (int k = 0; k < 25; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL wr_ch1: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
   endtask

   task automatic test_div0_div1();
      logic [7:0] obs;
      logic [7:0] ev;
      do_write(0, 0, 0, "div0");
      for (int k = 0; k < 20; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL div0: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
      do_write(0, 1, 0, "div1");
      for (int k = 0; k < 20; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL div1: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
   endtask

   // Second write is issued while settling and must transfer exactly once, on the first locked edge
   task automatic test_hold_off();
      logic [7:0] obs;
      logic [7:0] ev;
      do_write(1, 2, 0, "hold_first");
      do_write(1, 3, 0, "hold_second");
      for (int k = 0; k < 20; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL hold_off: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
   endtask

   task automatic test_bad_ch();
      logic [7:0] obs;
      logic [7:0] ev;
      do_write(3, 7, 0, "bad_ch");
      for (int k = 0; k < 20; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL bad_ch: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
   endtask

`ifdef CLKEN_FRAC_EN
   // div=4, frac=0x80: periods 4,4,5,4,5,4,5 from the load edge
   task automatic test_frac();
      int   e0;
      logic want;
      do_write(2, 4, 8'h80, "frac_wr");
      e0 = edge_n;
      for (int k = 0; k < 32; k++) begin
         tick();
         want = ((edge_n - e0) inside {4, 8, 13, 17, 22, 26, 31});
         tests++;
         if (ce_o[2] !== want) begin
            fails++;
            $display("FAIL frac ce2: got %b want %b at load+%0d", ce_o[2], want, edge_n - e0);
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [7:0] obs;
      logic [7:0] ev;
      rst_n = 1'b0;
      #2;
      obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
      tests++;
      if (obs !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid assert: ce/clk/lock/rdy got %b want 00000000", obs);
      end
      @(negedge refclk);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 20; k++) begin
         tick();
         obs = {ce_o, clk_o, locked, cfg_if.cfg_ready};
         ev  = exp_vec();
         tests++;
         if (obs !== ev) begin
            fails++;
            $display("FAIL reset_mid: ce/clk/lock/rdy got %b want %b at edge %0d", obs, ev, edge_n);
         end
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_div   = '0;
      cfg_if.cfg_frac  = '0;
      model_reset();
      repeat (3) @(negedge refclk);
      test_reset();
      rst_n = 1'b1;
      test_defaults();
      test_write_ch1();
      test_div0_div1();
      test_hold_off();
      test_bad_ch();
`ifdef CLKEN_FRAC_EN
      test_frac();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
